// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Buffers one tile of row vectors (LANES words per row, up to DEPTH rows)
//   and replays it onto the systolic array edge with diagonal skew: lane i
//   runs i cycles behind lane 0. Idle, hold and out-of-range beats drive
//   zeros, so a PE fed by them leaves its accumulator unchanged.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (abandons any tile in flight)
//   s_valid    upstream row vector valid
//   s_ready    feeder can accept a row (IDLE/LOAD only)
//   s_data     row vector, lane i at [i*WIDTH +: WIDTH]
//   s_last     final row of the tile
//   hold       stall request, freezes the feed sequence while in FEED
//   out_data   skewed lane words to the array edge, packed like s_data
//   out_valid  out_data is a live sequence beat
//   out_first  first live beat of a tile
//   done       one-cycle pulse after the final beat of a tile
module systolic_skew_feeder #(
   parameter int WIDTH = 16,
   parameter int LANES = 4,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [LANES*WIDTH-1:0] s_data,
   input  logic                   s_last,
   input  logic                   hold,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic                   out_valid,
   output logic                   out_first,
   output logic                   done
);

   localparam int CW = $clog2(DEPTH + LANES);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FEED,
      DONE
   } state_t;

   state_t                 state_reg;
   logic [CW-1:0]          l_reg;
   logic [CW-1:0]          t_reg;
   logic                   s_ready_reg;
   logic [LANES*WIDTH-1:0] out_data_reg;
   logic                   out_valid_reg;
   logic                   out_first_reg;
   logic                   done_reg;

   // Every lane reads a different row in the same cycle, so the tile lives
   // in a plain register array rather than a single-port RAM.
   logic [LANES*WIDTH-1:0] buf_mem [DEPTH];
   logic [LANES*WIDTH-1:0] skew_next;

   logic accept;
   logic load_end;
   logic last_beat;

   assign accept    = s_valid && s_ready_reg;
   // A full buffer ends the tile even without s_last.
   assign load_end  = s_last || (l_reg + CW'(1) == CW'(DEPTH));
   assign last_beat = (t_reg == l_reg + CW'(LANES - 2));

   always_ff @(posedge clk) begin
      for (int r = 0; r < DEPTH; r++) begin
         if (accept && l_reg == CW'(r)) begin
            buf_mem[r] <= s_data;
         end
      end
   end

   // Lane gi shows row t-gi when 0 <= t-gi < L. Matching t against r+gi
   // avoids an unsigned subtraction that could wrap.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [WIDTH-1:0] lane_word;

         always_comb begin
            lane_word = '0;
            for (int r = 0; r < DEPTH; r++) begin
               if (l_reg > CW'(r) && t_reg == CW'(r + gi)) begin
                  lane_word = buf_mem[r][gi*WIDTH +: WIDTH];
               end
            end
         end

         assign skew_next[gi*WIDTH +: WIDTH] = lane_word;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         l_reg         <= '0;
         t_reg         <= '0;
         s_ready_reg   <= 1'b0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_first_reg <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE, LOAD: begin
               out_data_reg  <= '0;
               out_valid_reg <= 1'b0;
               out_first_reg <= 1'b0;
               s_ready_reg   <= 1'b1;
               if (accept) begin
                  l_reg <= l_reg + CW'(1);
                  if (load_end) begin
                     state_reg   <= FEED;
                     s_ready_reg <= 1'b0;
                  end else begin
                     state_reg <= LOAD;
                  end
               end
            end

            FEED: begin
               s_ready_reg <= 1'b0;
               if (hold) begin
                  out_data_reg  <= '0;
                  out_valid_reg <= 1'b0;
                  out_first_reg <= 1'b0;
               end else begin
                  out_data_reg  <= skew_next;
                  out_valid_reg <= 1'b1;
                  out_first_reg <= (t_reg == '0);
                  t_reg         <= t_reg + CW'(1);
                  if (last_beat) begin
                     state_reg <= DONE;
                  end
               end
            end

            DONE: begin
               done_reg      <= 1'b1;
               out_data_reg  <= '0;
               out_valid_reg <= 1'b0;
               out_first_reg <= 1'b0;
               l_reg         <= '0;
               t_reg         <= '0;
               s_ready_reg   <= 1'b1;
               state_reg     <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign s_ready   = s_ready_reg;
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_first = out_first_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Testbench for systolic_skew_feeder (LANES=4, WIDTH=16, DEPTH=8).
// Row r lane i carries 16'h0r0i. Expected beats are hand-computed.
module tb_systolic_skew_feeder;

   localparam int WIDTH = 16;
   localparam int LANES = 4;
   localparam int DEPTH = 8;
   localparam int DW    = LANES * WIDTH;

   logic          clk = 1'b0;
   logic          reset;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          hold;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_first;
   logic          done;

   systolic_skew_feeder #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .hold      (hold),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_first (out_first),
      .done      (done)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Samples taken k cycles after the final row handshake (k = 1..).
   logic [DW-1:0] cap_data  [32];
   logic          cap_valid [32];
   logic          cap_first [32];
   logic          cap_done  [32];
   logic          cap_ready [32];

   typedef struct {
      int            scen;
      int            k;
      logic          valid;
      logic          first;
      logic          dn;
      logic          ready;
      logic [DW-1:0] data;
   } vec_t;

   vec_t vecs [$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] row_word(input int r);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < LANES; i++) begin
         d[i*WIDTH +: WIDTH] = {8'(r), 8'(i)};
      end
      return d;
   endfunction

   // Loads n rows; s_last on the final row when use_last. gap_at inserts one
   // idle cycle before that row index.
   task automatic load_rows(input int n, input bit use_last, input int gap_at);
      for (int r = 0; r < n; r++) begin
         int waited;
         if (r == gap_at) begin
            s_valid = 1'b0;
            tick();
         end
         waited = 0;
         while (s_ready !== 1'b1 && waited < 20) begin
            s_valid = 1'b0;
            tick();
            waited++;
         end
         if (s_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL s_ready_timeout: got %b expected 1", s_ready);
         end
         s_valid = 1'b1;
         s_data  = row_word(r);
         s_last  = use_last && (r == n - 1);
         tick();
         $display("[TB] load row %0d data %h last %b", r, s_data, s_last);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
   endtask

   task automatic capture(input int ncyc, input int hold_start, input int hold_len);
      for (int k = 1; k <= ncyc; k++) begin
         hold = (k >= hold_start) && (k < hold_start + hold_len);
         tick();
         cap_data[k]  = out_data;
         cap_valid[k] = out_valid;
         cap_first[k] = out_first;
         cap_done[k]  = done;
         cap_ready[k] = s_ready;
      end
      hold = 1'b0;
   endtask

   task automatic run_vectors(input int scen);
      foreach (vecs[j]) begin
         if (vecs[j].scen == scen) begin
            int k;
            k = vecs[j].k;
            $display("[TB] scen %0d k %0d data %h valid %b first %b done %b ready %b",
                     scen, k, cap_data[k], cap_valid[k], cap_first[k], cap_done[k], cap_ready[k]);
            check($sformatf("s%0d_k%0d_data", scen, k), cap_data[k], vecs[j].data);
            check($sformatf("s%0d_k%0d_valid", scen, k), DW'(cap_valid[k]), DW'(vecs[j].valid));
            check($sformatf("s%0d_k%0d_first", scen, k), DW'(cap_first[k]), DW'(vecs[j].first));
            check($sformatf("s%0d_k%0d_done", scen, k), DW'(cap_done[k]), DW'(vecs[j].dn));
            check($sformatf("s%0d_k%0d_ready", scen, k), DW'(cap_ready[k]), DW'(vecs[j].ready));
         end
      end
   endtask

   function automatic vec_t mk(input int scen, input int k, input logic v, input logic f,
                               input logic dn, input logic rdy, input logic [DW-1:0] d);
      vec_t x;
      x.scen = scen; x.k = k; x.valid = v; x.first = f; x.dn = dn; x.ready = rdy; x.data = d;
      return x;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats;
      int first_k;
      int last_k;
      int done_k;

      // Scenario 2: 3 rows, no hold.
      vecs.push_back(mk(2, 1, 1, 1, 0, 0, 64'h0000_0000_0000_0000));
      vecs.push_back(mk(2, 2, 1, 0, 0, 0, 64'h0000_0000_0001_0100));
      vecs.push_back(mk(2, 3, 1, 0, 0, 0, 64'h0000_0002_0101_0200));
      vecs.push_back(mk(2, 4, 1, 0, 0, 0, 64'h0003_0102_0201_0000));
      vecs.push_back(mk(2, 5, 1, 0, 0, 0, 64'h0103_0202_0000_0000));
      vecs.push_back(mk(2, 6, 1, 0, 0, 0, 64'h0203_0000_0000_0000));
      vecs.push_back(mk(2, 7, 0, 0, 1, 1, 64'h0));
      vecs.push_back(mk(2, 8, 0, 0, 0, 1, 64'h0));
      // Scenario 4: same tile, hold over beat t=2 for 3 cycles.
      vecs.push_back(mk(4, 1, 1, 1, 0, 0, 64'h0000_0000_0000_0000));
      vecs.push_back(mk(4, 2, 1, 0, 0, 0, 64'h0000_0000_0001_0100));
      vecs.push_back(mk(4, 3, 0, 0, 0, 0, 64'h0));
      vecs.push_back(mk(4, 4, 0, 0, 0, 0, 64'h0));
      vecs.push_back(mk(4, 5, 0, 0, 0, 0, 64'h0));
      vecs.push_back(mk(4, 6, 1, 0, 0, 0, 64'h0000_0002_0101_0200));
      vecs.push_back(mk(4, 7, 1, 0, 0, 0, 64'h0003_0102_0201_0000));
      vecs.push_back(mk(4, 8, 1, 0, 0, 0, 64'h0103_0202_0000_0000));
      vecs.push_back(mk(4, 9, 1, 0, 0, 0, 64'h0203_0000_0000_0000));
      vecs.push_back(mk(4, 10, 0, 0, 1, 1, 64'h0));
      // Scenario 5: single-row tile.
      vecs.push_back(mk(5, 1, 1, 1, 0, 0, 64'h0000_0000_0000_0000));
      vecs.push_back(mk(5, 2, 1, 0, 0, 0, 64'h0000_0000_0001_0000));
      vecs.push_back(mk(5, 3, 1, 0, 0, 0, 64'h0000_0002_0000_0000));
      vecs.push_back(mk(5, 4, 1, 0, 0, 0, 64'h0003_0000_0000_0000));
      vecs.push_back(mk(5, 5, 0, 0, 1, 1, 64'h0));
      // Scenario 6: 2-row tile after an abandoned one.
      vecs.push_back(mk(6, 1, 1, 1, 0, 0, 64'h0000_0000_0000_0000));
      vecs.push_back(mk(6, 2, 1, 0, 0, 0, 64'h0000_0000_0001_0100));
      vecs.push_back(mk(6, 3, 1, 0, 0, 0, 64'h0000_0002_0101_0000));
      vecs.push_back(mk(6, 4, 1, 0, 0, 0, 64'h0003_0102_0000_0000));
      vecs.push_back(mk(6, 5, 1, 0, 0, 0, 64'h0103_0000_0000_0000));
      vecs.push_back(mk(6, 6, 0, 0, 1, 1, 64'h0));

      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      hold    = 1'b0;

      // Scenario 1: reset state and idle outputs.
      tick();
      tick();
      check("rst_data", out_data, '0);
      check("rst_valid", DW'(out_valid), '0);
      check("rst_first", DW'(out_first), '0);
      check("rst_done", DW'(done), '0);
      check("rst_ready", DW'(s_ready), '0);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         $display("[TB] idle cycle %0d ready %b valid %b", c, s_ready, out_valid);
         check($sformatf("idle%0d_ready", c), DW'(s_ready), DW'(1'b1));
         check($sformatf("idle%0d_valid", c), DW'(out_valid), '0);
         check($sformatf("idle%0d_data", c), out_data, '0);
         check($sformatf("idle%0d_done", c), DW'(done), '0);
      end

      // Scenario 2.
      load_rows(3, 1'b1, -1);
      check("s2_ready_after_last", DW'(s_ready), '0);
      capture(8, 99, 0);
      run_vectors(2);

      // Scenario 3: 8 rows, no s_last, one gap.
      load_rows(8, 1'b0, 4);
      check("s3_ready_full", DW'(s_ready), '0);
      capture(14, 99, 0);
      beats = 0; first_k = 0; last_k = 0; done_k = 0;
      for (int k = 1; k <= 14; k++) begin
         if (cap_valid[k]) begin
            beats++;
            last_k = k;
         end
         if (cap_first[k] && first_k == 0) first_k = k;
         if (cap_done[k] && done_k == 0) done_k = k;
      end
      $display("[TB] scen 3 beats %0d first_k %0d last_k %0d done_k %0d", beats, first_k, last_k, done_k);
      check("s3_beats", DW'(beats), DW'(11));
      check("s3_first_k", DW'(first_k), DW'(1));
      check("s3_last_k", DW'(last_k), DW'(11));
      check("s3_last_data", cap_data[11], 64'h0703_0000_0000_0000);
      check("s3_done_k", DW'(done_k), DW'(12));

      // Scenario 4.
      load_rows(3, 1'b1, -1);
      capture(11, 3, 3);
      run_vectors(4);
      beats = 0;
      for (int k = 1; k <= 11; k++) if (cap_valid[k]) beats++;
      check("s4_beats", DW'(beats), DW'(6));

      // Scenario 5.
      load_rows(1, 1'b1, -1);
      capture(6, 99, 0);
      run_vectors(5);

      // Scenario 6: reset at beat t=2, then a fresh 2-row tile.
      load_rows(3, 1'b1, -1);
      capture(2, 99, 0);
      check("s6_pre_t1", cap_data[2], 64'h0000_0000_0001_0100);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("s6_rst_valid", DW'(out_valid), '0);
      check("s6_rst_done", DW'(done), '0);
      done_k = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done) done_k++;
      end
      check("s6_no_done", DW'(done_k), '0);
      load_rows(2, 1'b1, -1);
      capture(7, 99, 0);
      run_vectors(6);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the processingelement systolic array.
- Buffers one tile of row vectors (LANES words per row, up to DEPTH rows).
- Replays the tile onto the array edge with diagonal skew: lane i is delayed i cycles relative to lane 0, so operands meet in the correct PE.
- Idle and stall beats drive zeros. A PE that multiplies zeros adds 0 to its accumulator, so its out_c is unchanged.

Parameters:
- WIDTH, 16, bit width of one operand word; matches the PE WIDTH.
- LANES, 4, number of array rows/columns fed (one word per lane per cycle).
- DEPTH, 8, maximum rows per tile (reduction length K).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream row vector valid.
- s_ready  output  1  feeder can accept a row.
- s_data  input  LANES*WIDTH  row vector; lane i at bits [i*WIDTH +: WIDTH].
- s_last  input  1  marks the final row of the tile (qualified by s_valid&&s_ready).
- hold  input  1  stall request; freezes the feed sequence.
- out_data  output  LANES*WIDTH  skewed words to the array edge in_a/in_b, lane-packed as s_data.
- out_valid  output  1  out_data is a live sequence beat.
- out_first  output  1  high on the first live beat of a tile.
- done  output  1  one-cycle pulse after the final beat of a tile.

Behaviour:
- Reset, synchronous:
  - state=IDLE, row count L=0, feed counter t=0.
  - out_data=0, out_valid=0, out_first=0, done=0, s_ready=0.
  - Buffer contents are don't-care.
  - Reset asserted mid-LOAD or mid-FEED abandons the tile. No done pulse is produced.
- States: IDLE, LOAD, FEED, DONE. All outputs are registered.
- IDLE:
  - s_ready=1.
  - The first accepted row is written to buf[0], L=1, and the state moves to LOAD.
  - If that row also has s_last, the state moves straight to FEED.
- LOAD:
  - s_ready=1.
  - Each accepted row is written to buf[L], then L increments.
  - Move to FEED when the accepted row has s_last, or when L reaches DEPTH (s_last is then implied; a later s_last is not expected).
  - s_valid low inserts gaps and has no other effect.
- FEED:
  - s_ready=0 and t runs 0..L+LANES-2.
  - Each non-hold cycle registers lane i of out_data = buf[t-i][lane i] when 0<=t-i<L, else 0.
  - In that same cycle out_valid=1, out_first=(t==0), and t increments.
  - A hold cycle registers out_data=0, out_valid=0 and out_first=0, and t is frozen. The next non-hold beat resumes at the same t.
  - After the beat with t=L+LANES-2 the state moves to DONE.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. s_ready returns to 1 on the following cycle.
- Latency:
  - FEED is entered the cycle after the last row handshake (cycle c).
  - The first live beat appears at cycle c+2.
  - With no hold there are exactly L+LANES-1 consecutive live beats.
  - done is asserted on the cycle after the last beat.
- Widths: t and L use clog2(DEPTH+LANES) bits. The t-i comparison is done without unsigned wrap, i.e. as t>=i && t-i<L.
- A handshake is impossible outside IDLE/LOAD because s_ready is low.
- hold is ignored outside FEED.

Test Plan (LANES=4, WIDTH=16, DEPTH=8; row r lane i word = 16'h0r0i):
1. Reset, then check idle outputs:
   - Hold reset 2 cycles, then release.
   - All outputs are 0.
   - s_ready=1 from the first post-reset cycle onward.
2. Load 3 rows (last row at cycle c), no hold:
   - out_valid is high on cycles c+2..c+7 (6 beats); out_first only at c+2.
   - Beat t=0 = {0,0,0,0x0000}.
   - Beat t=3 lane3 = 0x0003 and lane0 = 0 (since L=3).
   - Beat t=5 = {0x0203,0,0,0}.
   - done at c+8.
3. Load 8 rows with s_last=0 on every row:
   - LOAD terminates at L=8 and s_ready drops.
   - 11 beats follow, with the last beat lane3 = 0x0703.
4. Same stimulus as scenario 2, with hold=1 at beat t=2 for 3 cycles:
   - Those 3 cycles show out_data=0 and out_valid=0.
   - The next beat is t=2 = {0,0x0101? no, 0x0002 at lane2, 0x0101 at lane1, 0x0200 at lane0}; lane3 is 0.
   - Total live beats is still 6.
5. Single-row tile, s_last on the first row:
   - 4 beats; beat t=i has only lane i nonzero, value 0x000i.
   - done follows the fourth beat.
6. Assert reset at FEED beat t=2:
   - Next cycle out_valid=0 and no done pulse.
   - A new 2-row tile then loads and feeds correctly (5 beats).
